// File: rtl/instruction_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_stage_if
// Brief   : Fetch-stage bundle: instruction-memory port, redirect/stall
//           controls from ID/EX and the IF/ID pipeline register outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface instruction_fetch_stage_if;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic [31:0] instruction_id;
  logic [31:0] pcplus4_id;
  logic        valid_id;
  logic        addrfault_id;
  logic [31:0] fetch_count;

  modport master (
    input  instruction, stall,
    input  branch_taken, branch_target,
    input  jump, jump_target,
    input  jump_reg, jump_reg_target,
    output address, instruction_id, pcplus4_id,
    output valid_id, addrfault_id, fetch_count
  );

  modport slave (
    output instruction, stall,
    output branch_taken, branch_target,
    output jump, jump_target,
    output jump_reg, jump_reg_target,
    input  address, instruction_id, pcplus4_id,
    input  valid_id, addrfault_id, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_stage
// Brief   : MIPS IF stage - PC, IF/ID register, redirect/stall handling and
//           retired-fetch counter.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  instruction_fetch_stage_if.master    bus
);

  localparam logic [31:0] c_mem_words = MEM_WORDS;

  logic [31:0] r_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_pcplus4_id;
  logic        r_valid_id;
  logic        r_fault_id;
  logic [31:0] r_fetch_count;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_in_range;

  assign w_redirect = bus.jump_reg | bus.jump | bus.branch_taken;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_in_range = ({2'b00, r_pc[31:2]} < c_mem_words);

  // jr outranks j/jal, which outranks a taken branch
  always_comb begin
    w_target = bus.branch_target;
    if (bus.jump_reg)  w_target = bus.jump_reg_target;
    else if (bus.jump) w_target = bus.jump_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_instr_id    <= NOP_WORD;
      r_pcplus4_id  <= 32'd0;
      r_valid_id    <= 1'b0;
      r_fault_id    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (w_redirect) begin
      // A redirect overrides a stall and costs exactly one bubble
      r_pc          <= {w_target[31:2], 2'b00};
      r_instr_id    <= NOP_WORD;
      r_pcplus4_id  <= 32'd0;
      r_valid_id    <= 1'b0;
      r_fault_id    <= 1'b0;
    end else if (!bus.stall) begin
      r_pc          <= w_pc_plus4;
      r_pcplus4_id  <= w_pc_plus4;
      if (w_in_range) begin
        r_instr_id    <= bus.instruction;
        r_valid_id    <= 1'b1;
        r_fault_id    <= 1'b0;
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_instr_id    <= NOP_WORD;
        r_valid_id    <= 1'b0;
        r_fault_id    <= 1'b1;
      end
    end
  end

  assign bus.address        = r_pc;
  assign bus.instruction_id = r_instr_id;
  assign bus.pcplus4_id     = r_pcplus4_id;
  assign bus.valid_id       = r_valid_id;
  assign bus.addrfault_id   = r_fault_id;
  assign bus.fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_stage
// Brief   : Directed self-checking bench for instruction_fetch_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (1024),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word index i holds i*3
  assign bus.instruction = {2'b00, bus.address[31:2]} * 32'd3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.stall           = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.branch_target   = 32'd0;
    bus.jump            = 1'b0;
    bus.jump_target     = 32'd0;
    bus.jump_reg        = 1'b0;
    bus.jump_reg_target = 32'd0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.address !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want %h", bus.address, 32'h0); end
    vectors++; if (bus.instruction_id !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want %h", bus.instruction_id, 32'h0); end
    vectors++; if (bus.pcplus4_id !== 32'h0) begin miscompares++; $display("FAIL rst_pc4 got %h want %h", bus.pcplus4_id, 32'h0); end
    vectors++; if (bus.valid_id !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", bus.valid_id); end
    vectors++; if (bus.addrfault_id !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %b want 0", bus.addrfault_id); end
    vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bus.fetch_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_addr  = 32'(4 * i);
      exp_instr = 32'(3 * (i - 1));
      vectors++; if (bus.address !== exp_addr) begin miscompares++; $display("FAIL seq_addr[%0d] got %h want %h", i, bus.address, exp_addr); end
      vectors++; if (bus.instruction_id !== exp_instr) begin miscompares++; $display("FAIL seq_instr[%0d] got %h want %h", i, bus.instruction_id, exp_instr); end
      vectors++; if (bus.pcplus4_id !== exp_addr) begin miscompares++; $display("FAIL seq_pc4[%0d] got %h want %h", i, bus.pcplus4_id, exp_addr); end
      vectors++; if (bus.valid_id !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.valid_id); end
      vectors++; if (bus.fetch_count !== 32'(i)) begin miscompares++; $display("FAIL seq_count[%0d] got %0d want %0d", i, bus.fetch_count, i); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (bus.address !== 32'h8) begin miscompares++; $display("FAIL stall_addr[%0d] got %h want %h", i, bus.address, 32'h8); end
      vectors++; if (bus.instruction_id !== 32'd3) begin miscompares++; $display("FAIL stall_instr[%0d] got %h want %h", i, bus.instruction_id, 32'd3); end
      vectors++; if (bus.fetch_count !== 32'd2) begin miscompares++; $display("FAIL stall_count[%0d] got %0d want 2", i, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    step();
    vectors++; if (bus.instruction_id !== 32'd6) begin miscompares++; $display("FAIL stall_rel_instr got %h want %h", bus.instruction_id, 32'd6); end
    vectors++; if (bus.address !== 32'hC) begin miscompares++; $display("FAIL stall_rel_addr got %h want %h", bus.address, 32'hC); end
    vectors++; if (bus.fetch_count !== 32'd3) begin miscompares++; $display("FAIL stall_rel_count got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_branch_over_stall();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.stall         = 1'b1;
    step();
    clear_ctrl();
    vectors++; if (bus.address !== 32'h40) begin miscompares++; $display("FAIL br_addr got %h want %h", bus.address, 32'h40); end
    vectors++; if (bus.valid_id !== 1'b0) begin miscompares++; $display("FAIL br_valid got %b want 0", bus.valid_id); end
    vectors++; if (bus.instruction_id !== 32'h0) begin miscompares++; $display("FAIL br_bubble got %h want %h", bus.instruction_id, 32'h0); end
    vectors++; if (bus.pcplus4_id !== 32'h0) begin miscompares++; $display("FAIL br_bubble_pc4 got %h want %h", bus.pcplus4_id, 32'h0); end
    vectors++; if (bus.fetch_count !== 32'd3) begin miscompares++; $display("FAIL br_count got %0d want 3", bus.fetch_count); end
    step();
    vectors++; if (bus.instruction_id !== 32'd48) begin miscompares++; $display("FAIL br_instr got %0d want 48", bus.instruction_id); end
    vectors++; if (bus.pcplus4_id !== 32'h44) begin miscompares++; $display("FAIL br_pc4 got %h want %h", bus.pcplus4_id, 32'h44); end
    vectors++; if (bus.fetch_count !== 32'd4) begin miscompares++; $display("FAIL br_count2 got %0d want 4", bus.fetch_count); end
  endtask

  task automatic test_redirect_priority();
    bus.jump            = 1'b1;
    bus.jump_target     = 32'h100;
    bus.jump_reg        = 1'b1;
    bus.jump_reg_target = 32'h23;
    bus.branch_taken    = 1'b1;
    bus.branch_target   = 32'h80;
    step();
    vectors++; if (bus.address !== 32'h20) begin miscompares++; $display("FAIL prio_jr_addr got %h want %h", bus.address, 32'h20); end
    // j beats a taken branch once jr drops out
    bus.jump_reg = 1'b0;
    step();
    vectors++; if (bus.address !== 32'h100) begin miscompares++; $display("FAIL prio_j_addr got %h want %h", bus.address, 32'h100); end
    bus.jump            = 1'b1;
    bus.jump_target     = 32'h20;
    bus.branch_taken    = 1'b0;
    step();
    clear_ctrl();
    step();
    vectors++; if (bus.instruction_id !== 32'd24) begin miscompares++; $display("FAIL prio_instr got %0d want 24", bus.instruction_id); end
    vectors++; if (bus.pcplus4_id !== 32'h24) begin miscompares++; $display("FAIL prio_pc4 got %h want %h", bus.pcplus4_id, 32'h24); end
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("FAIL prio_count got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_out_of_range_and_wrap();
    bus.jump        = 1'b1;
    bus.jump_target = 32'h1000;
    step();
    clear_ctrl();
    vectors++; if (bus.address !== 32'h1000) begin miscompares++; $display("FAIL oor_addr got %h want %h", bus.address, 32'h1000); end
    step();
    vectors++; if (bus.valid_id !== 1'b0) begin miscompares++; $display("FAIL oor_valid got %b want 0", bus.valid_id); end
    vectors++; if (bus.addrfault_id !== 1'b1) begin miscompares++; $display("FAIL oor_fault got %b want 1", bus.addrfault_id); end
    vectors++; if (bus.instruction_id !== 32'h0) begin miscompares++; $display("FAIL oor_instr got %h want %h", bus.instruction_id, 32'h0); end
    vectors++; if (bus.pcplus4_id !== 32'h1004) begin miscompares++; $display("FAIL oor_pc4 got %h want %h", bus.pcplus4_id, 32'h1004); end
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("FAIL oor_count got %0d want 5", bus.fetch_count); end
    bus.jump        = 1'b1;
    bus.jump_target = 32'hFFFF_FFFC;
    step();
    clear_ctrl();
    vectors++; if (bus.address !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top got %h want %h", bus.address, 32'hFFFF_FFFC); end
    step();
    vectors++; if (bus.address !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h want %h", bus.address, 32'h0); end
    vectors++; if (bus.pcplus4_id !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4 got %h want %h", bus.pcplus4_id, 32'h0); end
    vectors++; if (bus.addrfault_id !== 1'b1) begin miscompares++; $display("FAIL wrap_fault got %b want 1", bus.addrfault_id); end
    step();
    vectors++; if (bus.valid_id !== 1'b1 || bus.addrfault_id !== 1'b0) begin miscompares++; $display("FAIL wrap_resume got v=%b f=%b want v=1 f=0", bus.valid_id, bus.addrfault_id); end
    vectors++; if (bus.fetch_count !== 32'd6) begin miscompares++; $display("FAIL wrap_count got %0d want 6", bus.fetch_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int i = 0; i < 7; i++) step();
    bus.jump        = 1'b1;
    bus.jump_target = 32'h20;
    step();
    clear_ctrl();
    bus.stall = 1'b1;
    step();
    vectors++; if (bus.address !== 32'h20 || bus.fetch_count !== 32'd7) begin miscompares++; $display("FAIL pre_rst got addr=%h cnt=%0d want addr=20 cnt=7", bus.address, bus.fetch_count); end
    // Pulse between edges must be ignored
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    vectors++; if (bus.address !== 32'h20 || bus.fetch_count !== 32'd7) begin miscompares++; $display("FAIL async_pulse got addr=%h cnt=%0d want addr=20 cnt=7", bus.address, bus.fetch_count); end
    rst = 1'b0;
    step();
    vectors++; if (bus.address !== 32'h0) begin miscompares++; $display("FAIL midrst_addr got %h want %h", bus.address, 32'h0); end
    vectors++; if (bus.valid_id !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.valid_id); end
    vectors++; if (bus.fetch_count !== 32'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", bus.fetch_count); end
    rst = 1'b1;
    clear_ctrl();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_redirect_priority();
    test_out_of_range_and_wrap();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
